// File: rtl/sseg_pkg.sv
// Shared types for the seven-segment scan controller.
package sseg_pkg;
  localparam int unsigned NDIG = 4;

  typedef logic [1:0] digit_sel_t;

  typedef enum logic {IDLE, PEND} scan_state_t;

  typedef struct packed {
    logic [15:0] data;
    logic        hex_dec;
    logic        sign;
  } disp_word_t;
endpackage

// File: rtl/sseg_scan_ctrl_slot_timer.sv
// slot_timer: per-digit prescaler, digit_sel counter and frame_tick pulse.
module slot_timer
  import sseg_pkg::*;
#(
  parameter int unsigned DIV = 100_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  output logic [$clog2(DIV)-1:0]  prescaler_next,
  output digit_sel_t              digit_sel,
  output logic                    frame_tick
);
  localparam int unsigned PW = $clog2(DIV);
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

  logic [PW-1:0] prescaler;
  logic          wrap;

  always_comb begin
    wrap           = en && (prescaler == PMAX);
    prescaler_next = prescaler;
    if (wrap) begin
      prescaler_next = '0;
    end else if (en) begin
      prescaler_next = prescaler + 1'b1;
    end
    frame_tick = wrap && (digit_sel == digit_sel_t'(NDIG - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      digit_sel <= '0;
    end else begin
      prescaler <= prescaler_next;
      if (wrap) begin
        digit_sel <= digit_sel + 1'b1;
      end
    end
  end
endmodule

// File: rtl/sseg_scan_ctrl.sv
// Seven-segment scan controller: digit timing, blanking, frame-aligned commit handshake.
// Optional SSEG_DIM_EN adds a bright[3:0] input that shortens the per-slot on-time.
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int unsigned DIV  = 100_000,
  parameter int unsigned DEAD = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] data_in,
  input  logic        hex_dec_in,
  input  logic        sign_in,
`ifdef SSEG_DIM_EN
  input  logic [3:0]  bright,
`endif
  input  logic        load,
  output logic        ready,
  output logic [15:0] data,
  output logic        hex_dec,
  output logic        sign,
  output digit_sel_t  digit_sel,
  output logic        blank,
  output logic        frame_tick
);
  localparam int unsigned PW = $clog2(DIV);

  logic [PW-1:0] prescaler_next;
  scan_state_t   state, state_next;
  disp_word_t    staging, staging_next;
  disp_word_t    shadow, shadow_next;
  logic          blank_next;

  slot_timer #(.DIV(DIV)) u_timer (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .prescaler_next (prescaler_next),
    .digit_sel      (digit_sel),
    .frame_tick     (frame_tick)
  );

  always_comb begin
    state_next   = state;
    staging_next = staging;
    shadow_next  = shadow;
    case (state)
      IDLE: begin
        if (load) begin
          staging_next = {data_in, hex_dec_in, sign_in};
          state_next   = PEND;
        end
      end
      PEND: begin
        if (frame_tick) begin
          shadow_next = staging;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      staging <= '0;
      shadow  <= '0;
    end else begin
      state   <= state_next;
      staging <= staging_next;
      shadow  <= shadow_next;
    end
  end

  assign ready   = (state == IDLE);
  assign data    = shadow.data;
  assign hex_dec = shadow.hex_dec;
  assign sign    = shadow.sign;

  // blank is evaluated against the prescaler value it will accompany, so the
  // dead time lines up exactly with the start of each new slot.
`ifdef SSEG_DIM_EN
  localparam int unsigned SLICE = (DIV - DEAD) / 16;

  logic [3:0]  bright_q;
  int unsigned on_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bright_q <= '0;
    end else if (prescaler_next == '0) begin
      bright_q <= bright;
    end
  end

  always_comb begin
    on_end     = DEAD + (32'(bright_q) + 1) * SLICE;
    blank_next = !en || (prescaler_next < PW'(DEAD)) || (32'(prescaler_next) >= on_end);
  end
`else
  always_comb begin
    blank_next = !en || (prescaler_next < PW'(DEAD));
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank <= 1'b1;
    end else begin
      blank <= blank_next;
    end
  end
endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Self-checking bench for sseg_scan_ctrl (DIV=8, DEAD=2, default build).
module tb_sseg_scan_ctrl;
  localparam int unsigned DIV   = 8;
  localparam int unsigned DEAD  = 2;
  localparam int unsigned FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] data_in = '0;
  logic        hex_dec_in = 1'b0;
  logic        sign_in = 1'b0;
  logic        load = 1'b0;
  logic        ready;
  logic [15:0] data;
  logic        hex_dec;
  logic        sign;
  logic [1:0]  digit_sel;
  logic        blank;
  logic        frame_tick;

  int checks = 0;
  int failures = 0;

  sseg_scan_ctrl #(.DIV(DIV), .DEAD(DEAD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .data_in    (data_in),
    .hex_dec_in (hex_dec_in),
    .sign_in    (sign_in),
    .load       (load),
    .ready      (ready),
    .data       (data),
    .hex_dec    (hex_dec),
    .sign       (sign),
    .digit_sel  (digit_sel),
    .blank      (blank),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // Reference model: n counts enabled cycles since reset; everything else follows from it.
  int unsigned n;
  bit          m_blank;
  bit          m_pend;
  logic [17:0] m_stage;
  logic [17:0] m_shadow;

  function automatic logic [22:0] dut_vec();
    return {ready, data, hex_dec, sign, digit_sel, blank, frame_tick};
  endfunction

  function automatic logic [22:0] mdl_vec();
    logic [1:0] dig;
    logic       tk;
    dig = 2'((n / DIV) % 4);
    tk  = en && ((n % FRAME) == FRAME - 1);
    return {!m_pend, m_shadow, dig, m_blank, tk};
  endfunction

  task automatic model_reset();
    n = 0; m_blank = 1'b1; m_pend = 1'b0; m_stage = '0; m_shadow = '0;
  endtask

  task automatic step();
    bit tick_now;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      tick_now = en && ((n % FRAME) == FRAME - 1);
      if (!m_pend) begin
        if (load) begin
          m_pend  = 1'b1;
          m_stage = {data_in, hex_dec_in, sign_in};
        end
      end else if (tick_now) begin
        m_shadow = m_stage;
        m_pend   = 1'b0;
      end
      if (en) n++;
      m_blank = !en || ((n % DIV) < DEAD);
    end
    @(negedge clk);
  endtask

  task automatic run_to_phase(input int unsigned phase);
    for (int i = 0; i < 2 * FRAME && (n % FRAME) != phase; i++) step();
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (dut_vec() !== {1'b1, 16'h0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", dut_vec(), {1'b1, 16'h0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_scan();
    int ticks = 0;
    en = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      if (frame_tick === 1'b1) ticks++;
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++;
        $display("FAIL scan cyc=%0d got=%h exp=%h", i, dut_vec(), mdl_vec());
      end
    end
    checks++;
    if (ticks != 2) begin
      failures++;
      $display("FAIL scan_tick_count got=%0d exp=2", ticks);
    end
  endtask

  task automatic test_load();
    run_to_phase(DIV + 3);
    data_in = 16'h1234; hex_dec_in = 1'b1; sign_in = 1'b0; load = 1'b1;
    step();
    load = 1'b0;
    checks++;
    if (ready !== 1'b0 || data !== 16'h0) begin
      failures++;
      $display("FAIL load_accept ready=%b data=%h exp ready=0 data=0000", ready, data);
    end
    step();
    data_in = 16'hBEEF; hex_dec_in = 1'b0; sign_in = 1'b1; load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < FRAME + 2 && m_pend; i++) begin
      step();
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++;
        $display("FAIL load_wait cyc=%0d got=%h exp=%h", i, dut_vec(), mdl_vec());
      end
    end
    checks++;
    if (data !== 16'h1234 || hex_dec !== 1'b1 || sign !== 1'b0 || ready !== 1'b1) begin
      failures++;
      $display("FAIL load_commit data=%h hex=%b sign=%b ready=%b exp 1234 1 0 1", data, hex_dec, sign, ready);
    end
  endtask

  task automatic test_load_on_tick();
    run_to_phase(FRAME - 1);
    checks++;
    if (frame_tick !== 1'b1 || ready !== 1'b1) begin
      failures++;
      $display("FAIL tick_precond tick=%b ready=%b exp 1 1", frame_tick, ready);
    end
    data_in = 16'hA5A5; hex_dec_in = 1'b0; sign_in = 1'b1; load = 1'b1;
    step();
    load = 1'b0;
    for (int k = 2; k <= 32; k++) begin
      step();
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++;
        $display("FAIL tick_defer k=%0d got=%h exp=%h", k, dut_vec(), mdl_vec());
      end
    end
    checks++;
    if (data !== 16'h1234 || ready !== 1'b0) begin
      failures++;
      $display("FAIL tick_not_early data=%h ready=%b exp 1234 0", data, ready);
    end
    step();
    checks++;
    if (data !== 16'hA5A5 || sign !== 1'b1 || ready !== 1'b1) begin
      failures++;
      $display("FAIL tick_commit data=%h sign=%b ready=%b exp a5a5 1 1", data, sign, ready);
    end
  endtask

  task automatic test_en_freeze();
    run_to_phase(FRAME - 1);
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (digit_sel !== 2'd3 || blank !== 1'b1 || frame_tick !== 1'b0) begin
        failures++;
        $display("FAIL freeze cyc=%0d digit=%0d blank=%b tick=%b exp 3 1 0", i, digit_sel, blank, frame_tick);
      end
    end
    en = 1'b1;
    #1;
    checks++;
    if (frame_tick !== 1'b1) begin
      failures++;
      $display("FAIL resume_tick got=%b exp=1", frame_tick);
    end
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++;
        $display("FAIL resume cyc=%0d got=%h exp=%h", i, dut_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_reset_pend();
    run_to_phase(2 * DIV + 3);
    data_in = 16'h7777; hex_dec_in = 1'b1; sign_in = 1'b1; load = 1'b1;
    step();
    load = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (data !== 16'h0 || ready !== 1'b1 || digit_sel !== 2'd0 || blank !== 1'b1 || hex_dec !== 1'b0) begin
      failures++;
      $display("FAIL reset_pend data=%h ready=%b digit=%0d blank=%b exp 0000 1 0 1", data, ready, digit_sel, blank);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < FRAME + 4; i++) begin
      step();
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++;
        $display("FAIL after_reset cyc=%0d got=%h exp=%h", i, dut_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      en         = ($urandom_range(0, 9) != 0);
      load       = ($urandom_range(0, 3) == 0);
      data_in    = 16'($urandom);
      hex_dec_in = 1'($urandom);
      sign_in    = 1'($urandom);
      #1;
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++;
        $display("FAIL random_pre cyc=%0d got=%h exp=%h", i, dut_vec(), mdl_vec());
      end
      step();
    end
    load = 1'b0;
    en   = 1'b1;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load();
    test_load_on_tick();
    test_en_freeze();
    test_reset_pend();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
